key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 196 +++++++++++++++++++
 tb/tb_key_debounce.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Multi-channel push-button conditioner. Each raw, asynchronous,
//             bouncing key input is synchronised into the clk domain and then
//             debounced by a per-channel four-state FSM with a stability
//             counter. Produces a clean "pressed" level plus registered
//             one-cycle press/release pulses per key.
//
//  Ports    : clk          system clock
//             resetn       asynchronous active-low reset
//             key_raw      [NUM_KEYS] raw pad inputs (async to clk)
//             key_level    [NUM_KEYS] debounced level, 1 = pressed
//             key_press    [NUM_KEYS] one-cycle pulse on key_level rise
//             key_release  [NUM_KEYS] one-cycle pulse on key_level fall
//             key_long     [NUM_KEYS] one-cycle long-press pulse
//
//  Options  : KEY_DEBOUNCE_LONGPRESS_EN - when defined, a per-channel held
//             counter drives key_long after LONG_CYCLES cycles held; when
//             undefined key_long is tied to 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 320000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_CYCLES     = 16000000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int                 c_CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DB_LIMIT     = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    // Raw pad level of a key that is not pressed; also the XOR mask that
    // normalises the synchronised sample to 1 = pressed.
    localparam logic               c_RAW_RELEASED = (ACTIVE_LOW != 0);

    localparam logic [1:0] c_ST_REL_STABLE = 2'd0;
    localparam logic [1:0] c_ST_PRESS_CHK  = 2'd1;
    localparam logic [1:0] c_ST_HELD       = 2'd2;
    localparam logic [1:0] c_ST_REL_CHK    = 2'd3;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key

        // ------------------------------------------------------------------
        // Synchroniser: resets to the released pad level so that a reset
        // never looks like a key event.
        // ------------------------------------------------------------------
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_pressed;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_sync <= {SYNC_STAGES{c_RAW_RELEASED}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw[g]};
            end
        end

        assign w_pressed = r_sync[SYNC_STAGES-1] ^ c_RAW_RELEASED;

        // ------------------------------------------------------------------
        // Debounce FSM
        // ------------------------------------------------------------------
        logic [1:0]         r_state;
        logic [1:0]         w_state_nxt;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;
        logic               r_level;
        logic               w_level_nxt;
        logic               r_press;
        logic               w_press_nxt;
        logic               r_release;
        logic               w_release_nxt;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_state   <= c_ST_REL_STABLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_level   <= w_level_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
            end
        end

        // The counter is cleared on every accept and every reject, so it
        // can never run past c_DB_LIMIT and never wraps.
        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_level_nxt   = r_level;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            case (r_state)
                c_ST_REL_STABLE: begin
                    if (w_pressed) begin
                        w_state_nxt = c_ST_PRESS_CHK;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                c_ST_PRESS_CHK: begin
                    if (!w_pressed) begin
                        w_state_nxt = c_ST_REL_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DB_LIMIT) begin
                        w_state_nxt = c_ST_HELD;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_HELD: begin
                    if (!w_pressed) begin
                        w_state_nxt = c_ST_REL_CHK;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                c_ST_REL_CHK: begin
                    if (w_pressed) begin
                        w_state_nxt = c_ST_HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DB_LIMIT) begin
                        w_state_nxt   = c_ST_REL_STABLE;
                        w_cnt_nxt     = '0;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_REL_STABLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
        end

        assign key_level[g]   = r_level;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        // ------------------------------------------------------------------
        // Long-press detection: counts cycles spent in HELD/REL_CHK, i.e.
        // while key_level is 1. A release bounce that returns to HELD keeps
        // the count, so the pulse fires at most once per press.
        // ------------------------------------------------------------------
        localparam int                  c_LONG_W     = $clog2(LONG_CYCLES + 1);
        localparam logic [c_LONG_W-1:0] c_LONG_LIMIT = c_LONG_W'(LONG_CYCLES);
        localparam logic [c_LONG_W-1:0] c_LONG_ONE   = c_LONG_W'(1);

        logic [c_LONG_W-1:0] r_hold_cnt;
        logic                r_long;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_hold_cnt <= '0;
                r_long     <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if ((r_state == c_ST_REL_STABLE) || (r_state == c_ST_PRESS_CHK)) begin
                    r_hold_cnt <= '0;
                end else if (r_hold_cnt != c_LONG_LIMIT) begin
                    r_hold_cnt <= r_hold_cnt + c_LONG_ONE;
                    r_long     <= ((r_hold_cnt + c_LONG_ONE) == c_LONG_LIMIT);
                end
            end
        end

        assign key_long[g] = r_long;
`else
        assign key_long[g] = 1'b0;
`endif

    end : g_key

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_debounce
//  Purpose  : Self-checking bench for key_debounce. A behavioural model
//             (sample delay line + per-key run length of "sample differs from
//             level") predicts every output each cycle; directed scenarios
//             measure latencies and pulse counts, followed by randomized
//             key activity with occasional asynchronous resets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int NK = 2;
    localparam int DB = 8;
    localparam int SS = 2;
    localparam int AL = 1;
    localparam int LC = 40;

    logic          clk     = 1'b0;
    logic          resetn  = 1'b1;
    logic [NK-1:0] key_raw = '0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS),
        .ACTIVE_LOW      (AL),
        .LONG_CYCLES     (LC)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    localparam logic [NK-1:0] c_RELEASED = (AL != 0) ? {NK{1'b1}} : {NK{1'b0}};

    logic [NK-1:0] m_dly [SS];
    int            m_run [NK];
    int            m_held[NK];
    logic [NK-1:0] m_level, m_press, m_release, m_long;

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_dly[i] = c_RELEASED;
        for (int k = 0; k < NK; k++) begin
            m_run[k]  = 0;
            m_held[k] = 0;
        end
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_long    = '0;
    endtask

    // One rising edge: the pressed sample seen now is the raw value captured
    // SS edges ago. A level change needs DB+1 consecutive differing samples.
    task automatic model_edge(input logic [NK-1:0] raw);
        logic [NK-1:0] s;
        s = m_dly[SS-1] ^ c_RELEASED;
        for (int i = SS-1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = raw;
        m_press   = '0;
        m_release = '0;
        m_long    = '0;
        for (int k = 0; k < NK; k++) begin
            if (m_level[k]) begin
                if (m_held[k] < LC) begin
                    m_held[k]++;
                    if (m_held[k] == LC) m_long[k] = 1'b1;
                end
            end else begin
                m_held[k] = 0;
            end
            if (s[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DB + 1) begin
                    m_level[k] = s[k];
                    if (s[k]) m_press[k] = 1'b1;
                    else      m_release[k] = 1'b1;
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
`ifndef KEY_DEBOUNCE_LONGPRESS_EN
        m_long = '0;
`endif
    endtask

    task automatic compare_all();
        check_val("level",   32'(key_level),   32'(m_level));
        check_val("press",   32'(key_press),   32'(m_press));
        check_val("release", 32'(key_release), 32'(m_release));
        check_val("long",    32'(key_long),    32'(m_long));
    endtask

    // ------------------------------------------------------------------
    // Per-scenario statistics; index 0 is the first edge that samples the
    // raw value applied after clear_stats.
    // ------------------------------------------------------------------
    int st_idx;
    int st_press_at[NK], st_press_cnt[NK];
    int st_rel_at[NK],   st_rel_cnt[NK];
    int st_long_at[NK],  st_long_cnt[NK];

    task automatic clear_stats();
        st_idx = 0;
        for (int k = 0; k < NK; k++) begin
            st_press_at[k] = -1; st_press_cnt[k] = 0;
            st_rel_at[k]   = -1; st_rel_cnt[k]   = 0;
            st_long_at[k]  = -1; st_long_cnt[k]  = 0;
        end
    endtask

    task automatic step(input logic [NK-1:0] raw);
        key_raw = raw;
        @(posedge clk);
        if (resetn) model_edge(raw);
        #1;
        compare_all();
        for (int k = 0; k < NK; k++) begin
            if (key_press[k])   begin st_press_cnt[k]++; if (st_press_at[k] < 0) st_press_at[k] = st_idx; end
            if (key_release[k]) begin st_rel_cnt[k]++;   if (st_rel_at[k]   < 0) st_rel_at[k]   = st_idx; end
            if (key_long[k])    begin st_long_cnt[k]++;  if (st_long_at[k]  < 0) st_long_at[k]  = st_idx; end
        end
        st_idx++;
    endtask

    task automatic async_reset_on();
        resetn = 1'b0;
        model_reset();
        #1;
        compare_all();
    endtask

    logic [NK-1:0] r_rand;
    int            len;
    int            lvl_at;

    initial begin
        model_reset();
        clear_stats();

        // Reset with both keys physically down
        #2;
        async_reset_on();
        repeat (3) step(2'b00);
        check_val("rst_no_press", 32'(st_press_cnt[0] + st_press_cnt[1]), 32'd0);
        resetn = 1'b1;
        clear_stats();
        lvl_at = -1;
        for (int i = 0; i < 16; i++) begin
            step(2'b00);
            if (lvl_at < 0 && key_level == 2'b11) lvl_at = i;
        end
        check_val("rst_rel_lat",   32'(lvl_at),         32'd10);
        check_val("rst_rel_p0",    32'(st_press_at[0]), 32'd10);
        check_val("rst_rel_p1",    32'(st_press_at[1]), 32'd10);
        repeat (14) step(2'b11);

        // Clean press / release on key 0
        clear_stats();
        repeat (14) step(2'b10);
        check_val("clean_press_at",  32'(st_press_at[0]),  32'd10);
        check_val("clean_press_cnt", 32'(st_press_cnt[0]), 32'd1);
        check_val("clean_k1_quiet",  32'(st_press_cnt[1]), 32'd0);
        clear_stats();
        repeat (14) step(2'b11);
        check_val("clean_rel_at",  32'(st_rel_at[0]),  32'd10);
        check_val("clean_rel_cnt", 32'(st_rel_cnt[0]), 32'd1);
        check_val("clean_k1_rel",  32'(st_rel_cnt[1]), 32'd0);

        // Bounce ending high: nothing happens
        clear_stats();
        repeat (4) begin
            repeat (5) step(2'b10);
            repeat (3) step(2'b11);
        end
        repeat (14) step(2'b11);
        check_val("bounce_hi_cnt", 32'(st_press_cnt[0]), 32'd0);
        check_val("bounce_hi_lvl", 32'(key_level[0]),    32'd0);

        // Bounce ending low: one press after the final falling edge
        clear_stats();
        repeat (4) begin
            repeat (5) step(2'b10);
            repeat (3) step(2'b11);
        end
        check_val("bounce_lo_pre", 32'(st_press_cnt[0]), 32'd0);
        clear_stats();
        repeat (14) step(2'b10);
        check_val("bounce_lo_at",  32'(st_press_at[0]),  32'd10);
        check_val("bounce_lo_cnt", 32'(st_press_cnt[0]), 32'd1);
        repeat (14) step(2'b11);

        // Simultaneous press, staggered release
        clear_stats();
        repeat (14) step(2'b00);
        check_val("simul_p0", 32'(st_press_at[0]), 32'd10);
        check_val("simul_p1", 32'(st_press_at[1]), 32'd10);
        clear_stats();
        repeat (3) step(2'b01);
        repeat (14) step(2'b11);
        check_val("simul_rel_gap", 32'(st_rel_at[1] - st_rel_at[0]), 32'd3);
        check_val("simul_rel_cnt", 32'(st_rel_cnt[0] + st_rel_cnt[1]), 32'd2);

        // Reset during PRESS_CHK (count 5) on key 1
        clear_stats();
        repeat (7) step(2'b01);
        async_reset_on();
        repeat (3) step(2'b01);
        check_val("midrst_no_pulse", 32'(st_press_cnt[1]), 32'd0);
        resetn = 1'b1;
        clear_stats();
        repeat (14) step(2'b01);
        check_val("midrst_press_at",  32'(st_press_at[1]),  32'd10);
        check_val("midrst_press_cnt", 32'(st_press_cnt[1]), 32'd1);
        repeat (14) step(2'b11);

        // Long hold on key 0
        clear_stats();
        repeat (72) step(2'b10);
        check_val("long_press_at", 32'(st_press_at[0]), 32'd10);
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        check_val("long_delay", 32'(st_long_at[0] - st_press_at[0]), 32'd40);
        check_val("long_cnt",   32'(st_long_cnt[0]), 32'd1);
`else
        check_val("long_cnt",   32'(st_long_cnt[0]), 32'd0);
`endif
        repeat (14) step(2'b11);

        // Randomized activity
        for (int seg = 0; seg < 300; seg++) begin
            r_rand = NK'($urandom);
            if ($urandom_range(0, 9) < 7) len = $urandom_range(1, 14);
            else                          len = $urandom_range(9, 60);
            if ($urandom_range(0, 39) == 0) begin
                async_reset_on();
                repeat (2) step(r_rand);
                resetn = 1'b1;
            end
            repeat (len) step(r_rand);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
